uart_line_arbiter: RTL and testbench
====================================

Name: uart_line_arbiter

Overview:
- Shares the single UART TX line feeder among NUM_REQ line producers, e.g. accelerometer readout, status/mode text and error banner.
- Arbitrates pending requests round-robin and presents the granted 34-byte ASCII line to the feeder.
- Drives the feeder's go strobe and tracks completion by snooping the feeder's TX valid strobe.
- Sits between the line-formatting logic and the feeder, all in the 20 MHz domain.

Parameters:
- NUM_REQ, 3: number of line requesters, 2..8.
- LINE_BYTES, 34: bytes per line; must match the feeder's fixed line length.
- TIMEOUT_CYCLES, 2000000: watchdog limit, in clocks, for one transaction (100 ms at 20 MHz).
- GAP_CYCLES, 2: idle clocks with go low after each transaction; minimum 2.

Ports:
- i_clk_20mhz  in  1  system clock.
- i_rst_20mhz  in  1  reset, synchronous, active-high.
- i_req  in  NUM_REQ  per-requester line request; level, held until o_ack.
- i_lines  in  NUM_REQ*LINE_BYTES*8  concatenated lines; requester k occupies slice k; first transmitted byte is the MSB byte.
- o_ack  out  NUM_REQ  one-cycle, one-hot pulse: line of requester k has been latched.
- o_done  out  NUM_REQ  one-cycle, one-hot pulse: LINE_BYTES bytes of requester k were enqueued.
- o_timeout  out  1  one-cycle pulse: watchdog aborted the transaction.
- o_busy  out  1  high from grant through the end of the gap.
- o_grant_idx  out  3  index of the current or last granted requester.
- o_feed_go  out  1  go strobe to the feeder.
- o_feed_line  out  LINE_BYTES*8  registered line to the feeder.
- i_feed_valid  in  1  copy of the feeder's TX valid output; one pulse per enqueued byte.

Behaviour:
- Reset values: state IDLE, all outputs 0, o_feed_line = LINE_BYTES spaces (0x20), priority pointer = 0, counters = 0.
- States: IDLE, GRANT, SEND, GAP.
- IDLE:
  - If any i_req bit is set, select the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - Latch that slice into o_feed_line and set o_grant_idx.
  - Pulse o_ack[k] in the same cycle. The requester may change i_lines[k] or drop i_req[k] from the next cycle.
  - Go to GRANT.
- GRANT:
  - Assert o_feed_go, clear the byte counter and watchdog, go to SEND.
  - Total latency from request seen in IDLE to o_feed_go high: 2 clocks.
- SEND:
  - Hold o_feed_go high and o_feed_line stable throughout. The feeder samples the line while waiting on its own TX ready, so the line must not change.
  - Each i_feed_valid increments the byte counter.
  - On the pulse that makes the count equal LINE_BYTES: pulse o_done[k], drop o_feed_go next cycle, set pointer = (k+1) mod NUM_REQ, go to GAP.
  - Watchdog counts every SEND cycle. On reaching TIMEOUT_CYCLES-1 without completion: pulse o_timeout, no o_done, drop go, advance pointer the same way, go to GAP.
- GAP:
  - o_feed_go low for exactly GAP_CYCLES clocks so the feeder returns from its wait state to idle.
  - Then IDLE. o_busy falls on entry to IDLE.
- i_feed_valid outside SEND is ignored and does not count.
- A counter overflow is impossible: the count saturates at LINE_BYTES and the state exits.
- Simultaneous requests: exactly one ack per transaction. A requester still asserted is re-granted only after every other pending requester has been served once.
- A request arriving during a transaction waits. A request dropped before ack is never granted.
- Byte counter width: clog2(LINE_BYTES+1). Watchdog width: clog2(TIMEOUT_CYCLES).
- Reset mid-transaction returns to the reset values next clock with o_feed_go low. The feeder shares the same reset.

Decomposition:
- Shared package uart_feed_pkg holds:
  - the state typedef t_linearb_state;
  - the LINE_BYTES default of 34;
  - the space-filled line constant;
  - a function that selects a requester slice.
- Sub-module rr_priority_pick: combinational round-robin picker with inputs req and pointer, outputs grant one-hot and index. It is reusable for other shared resources.

Test Plan:
- Single request: i_req=3'b010 with line "ACL X..." -> o_ack=010 one cycle later; o_feed_go high 2 clocks after the request; after 34 i_feed_valid pulses o_done=010; go low; o_busy low after 2 gap clocks.
- Simultaneous requests: i_req=3'b111 held after each ack is re-asserted -> grant order 0,1,2,0; each o_done precedes the next o_ack by ≥ GAP_CYCLES+1 clocks.
- Line stability: change i_lines[0] immediately after o_ack[0] -> o_feed_line unchanged until o_done[0]; the feeder model emits the original 34 bytes.
- Stall and timeout: TIMEOUT_CYCLES=1000, feeder TX ready held low -> o_timeout at cycle 1000 of SEND; no o_done; pointer advances; a pending requester 1 is served next.
- Stray valid: i_feed_valid pulses in IDLE and GAP -> no count change; the next transaction still needs exactly 34 pulses.
- Reset mid-SEND after 10 bytes: assert i_rst_20mhz one clock -> o_feed_go=0, o_busy=0, o_feed_line = 34 spaces; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/uart_feed_pkg.sv
// Shared types and constants for the UART line feeder path.
// Arbiter FSM encoding, default line geometry and line helpers.
package uart_feed_pkg;

  typedef logic [1:0] t_linearb_state;

  localparam t_linearb_state ST_IDLE  = 2'd0;
  localparam t_linearb_state ST_GRANT = 2'd1;
  localparam t_linearb_state ST_SEND  = 2'd2;
  localparam t_linearb_state ST_GAP   = 2'd3;

  localparam int unsigned LINE_BYTES_DEF = 34;
  localparam int unsigned LINE_W_DEF     = LINE_BYTES_DEF * 8;
  localparam int unsigned MAX_REQ        = 8;

  localparam logic [LINE_W_DEF-1:0] SPACE_LINE = {LINE_BYTES_DEF{8'h20}};

  // Slice k of a concatenated line bus (requester k at bits k*LINE_W_DEF upward)
  function automatic logic [LINE_W_DEF-1:0] line_slice(
    input logic [MAX_REQ*LINE_W_DEF-1:0] lines,
    input logic [2:0]                    k
  );
    return lines[32'(k)*LINE_W_DEF +: LINE_W_DEF];
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set req bit at or above pointer,
// wrapping modulo N. Grant is one-hot, index is its binary position.
module rr_priority_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic        found;
  int unsigned cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(pointer) + i) % N;
      if (!found && req[CW'(cand)]) begin
        found             = 1'b1;
        grant[CW'(cand)]  = 1'b1;
        index             = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_line_arbiter.sv
// Round-robin arbiter sharing the UART TX line feeder among NUM_REQ line
// producers; drives the feeder go strobe and counts enqueued bytes.
module uart_line_arbiter
  import uart_feed_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned LINE_BYTES     = LINE_BYTES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic                          i_clk_20mhz,
  input  logic                          i_rst_20mhz,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*LINE_BYTES*8-1:0] i_lines,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_done,
  output logic                          o_timeout,
  output logic                          o_busy,
  output logic [2:0]                    o_grant_idx,
  output logic                          o_feed_go,
  output logic [LINE_BYTES*8-1:0]       o_feed_line,
  input  logic                          i_feed_valid
);

  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam int unsigned CNT_W  = $clog2(LINE_BYTES + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [LINE_W-1:0] IDLE_LINE = {LINE_BYTES{8'h20}};

  t_linearb_state      state, state_nxt;
  logic [2:0]          ptr, ptr_nxt;
  logic [CNT_W-1:0]    byte_cnt, byte_nxt;
  logic [WD_W-1:0]     wd_cnt, wd_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_nxt;

  logic [NUM_REQ-1:0]  ack_nxt, done_nxt;
  logic                timeout_nxt, busy_nxt, go_nxt, end_txn;
  logic [2:0]          idx_nxt;
  logic [LINE_W-1:0]   line_nxt, sel_line;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [2:0]          pick_idx;

  rr_priority_pick #(
    .N  (NUM_REQ),
    .IW (3)
  ) u_pick (
    .req     (i_req),
    .pointer (ptr),
    .grant   (pick_grant),
    .index   (pick_idx)
  );

  // Line mux for the picked requester
  always_comb begin
    sel_line = IDLE_LINE;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == 3'(k)) sel_line = i_lines[k*LINE_W +: LINE_W];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    byte_nxt    = byte_cnt;
    wd_nxt      = wd_cnt;
    gap_nxt     = gap_cnt;
    ack_nxt     = '0;
    done_nxt    = '0;
    timeout_nxt = 1'b0;
    busy_nxt    = o_busy;
    go_nxt      = o_feed_go;
    idx_nxt     = o_grant_idx;
    line_nxt    = o_feed_line;
    end_txn     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|i_req) begin
          ack_nxt   = pick_grant;
          line_nxt  = sel_line;
          idx_nxt   = pick_idx;
          busy_nxt  = 1'b1;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        go_nxt    = 1'b1;
        byte_nxt  = '0;
        wd_nxt    = '0;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        wd_nxt = wd_cnt + WD_W'(1);
        if (i_feed_valid) begin
          byte_nxt = byte_cnt + CNT_W'(1);
          if (byte_cnt == CNT_W'(LINE_BYTES - 1)) begin
            done_nxt = NUM_REQ'(1) << o_grant_idx;
            end_txn  = 1'b1;
          end
        end
        // Completion wins over the watchdog when both land on one cycle
        if (!end_txn && wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_nxt = 1'b1;
          end_txn     = 1'b1;
        end
        if (end_txn) begin
          go_nxt    = 1'b0;
          ptr_nxt   = (o_grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : o_grant_idx + 3'd1;
          gap_nxt   = '0;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      byte_cnt    <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      o_ack       <= '0;
      o_done      <= '0;
      o_timeout   <= 1'b0;
      o_busy      <= 1'b0;
      o_grant_idx <= '0;
      o_feed_go   <= 1'b0;
      o_feed_line <= IDLE_LINE;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      byte_cnt    <= byte_nxt;
      wd_cnt      <= wd_nxt;
      gap_cnt     <= gap_nxt;
      o_ack       <= ack_nxt;
      o_done      <= done_nxt;
      o_timeout   <= timeout_nxt;
      o_busy      <= busy_nxt;
      o_grant_idx <= idx_nxt;
      o_feed_go   <= go_nxt;
      o_feed_line <= line_nxt;
    end
  end

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Bench for uart_line_arbiter: timeline-based reference model checked every
// cycle, directed scenarios with literal pins, then randomized traffic.
module tb_uart_line_arbiter;
  import uart_feed_pkg::*;

  localparam int NR  = 3;
  localparam int LB  = 34;
  localparam int LW  = LB * 8;
  localparam int TO  = 1000;
  localparam int GAP = 2;
  localparam int CW  = $clog2(NR);
  localparam longint INF = 64'sd1099511627776;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*LW-1:0] lines;
  logic            valid;
  logic [NR-1:0]   ack, done;
  logic            to, busy, go;
  logic [2:0]      gidx;
  logic [LW-1:0]   fline;

  always #25 clk = ~clk;

  uart_line_arbiter #(
    .NUM_REQ        (NR),
    .LINE_BYTES     (LB),
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (GAP)
  ) dut (
    .i_clk_20mhz  (clk),
    .i_rst_20mhz  (rst),
    .i_req        (req),
    .i_lines      (lines),
    .o_ack        (ack),
    .o_done       (done),
    .o_timeout    (to),
    .o_busy       (busy),
    .o_grant_idx  (gidx),
    .o_feed_go    (go),
    .o_feed_line  (fline),
    .i_feed_valid (valid)
  );

  int     n_vec = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  // Model: one transaction described by its grant edge and end edge
  bit            m_active;
  longint        m_tg, m_te, m_free;
  bit            m_to;
  int            m_k, m_ptr, m_bytes;
  logic [LW-1:0] m_line;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r = '0;
    for (int i = 0; i < 9; i++) r = (r << 32) | LW'($urandom);
    return r;
  endfunction

  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int off = 0; off < NR; off++) begin
      int c = (p + off) % NR;
      if (r[CW'(c)]) return c;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[CW'(i)]) return i;
    return -1;
  endfunction

  // Advance the model across edge p using the inputs about to be sampled
  task automatic model_update(input longint p);
    if (rst) begin
      m_active = 0; m_tg = -100; m_te = -100; m_to = 0;
      m_k = 0; m_ptr = 0; m_bytes = 0; m_line = SPACE_LINE; m_free = p + 1;
    end else if (!m_active && p >= m_free && (|req)) begin
      m_k      = pick(req, m_ptr);
      m_line   = line_slice((MAX_REQ*LINE_W_DEF)'(lines), 3'(m_k));
      m_tg     = p;
      m_te     = INF;
      m_to     = 0;
      m_bytes  = 0;
      m_active = 1;
    end else if (m_active && p >= m_tg + 2) begin
      if (valid) m_bytes++;
      if (m_bytes == LB) begin
        m_te = p; m_to = 0;
      end else if (p == m_tg + 1 + TO) begin
        m_te = p; m_to = 1;
      end
      if (m_te == p) begin
        m_active = 0;
        m_ptr    = (m_k + 1) % NR;
        m_free   = p + GAP + 1;
      end
    end
  endtask

  task automatic compare(input longint p);
    logic [NR-1:0] oh = NR'(1) << m_k;
    chk("ack",       LW'(ack),  (p == m_tg) ? LW'(oh) : '0);
    chk("feed_go",   LW'(go),   LW'(p > m_tg && p < m_te));
    chk("busy",      LW'(busy), LW'(p >= m_tg && p < m_te + GAP));
    chk("done",      LW'(done), (p == m_te && !m_to) ? LW'(oh) : '0);
    chk("timeout",   LW'(to),   LW'(p == m_te && m_to));
    chk("grant_idx", LW'(gidx), LW'(m_k));
    chk("feed_line", fline,     m_line);
  endtask

  task automatic tick();
    model_update(cyc);
    @(negedge clk);
    compare(cyc);
    cyc++;
  endtask

  initial begin
    logic [LW-1:0] sp  = {34{8'h20}};
    logic [LW-1:0] acl = "ACL X=+0012 Y=-0034 Z=+0998 mg    ";
    int            exp_order [4] = '{0, 1, 2, 0};
    longint        last_done = -1000;
    int            got;
    longint        at_ack;
    bit            seen;
    bit            stall;

    rst = 1'b1; req = '0; valid = 1'b0;
    for (int k = 0; k < NR; k++) lines[k*LW +: LW] = rand_line();
    tick(); tick();
    chk("reset_line", fline, sp);
    chk("reset_busy", LW'(busy), '0);
    chk("reset_go",   LW'(go),   '0);
    chk("reset_ack",  LW'(ack),  '0);
    rst = 1'b0;
    tick();

    // Simultaneous requests held high: order 0,1,2,0
    req = '1; valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      got = -1; at_ack = 0; seen = 0;
      for (int w = 0; w < 12 && got < 0; w++) begin
        tick();
        if (|ack) begin got = idx_of(ack); at_ack = cyc - 1; end
      end
      chk("rr_order", LW'(got), LW'(exp_order[t]));
      if (t > 0) chk("done_to_ack_spacing", LW'(at_ack - last_done >= 3), LW'(1));
      for (int w = 0; w < 60 && !seen; w++) begin
        tick();
        if (|done) begin seen = 1; last_done = cyc - 1; end
      end
      chk("rr_done_seen", LW'(seen), LW'(1));
    end
    req = '0; valid = 1'b0;
    tick(); tick(); tick();

    // Single request with line stability after ack
    lines[1*LW +: LW] = acl;
    req = 3'b010;
    tick();
    chk("single_ack", LW'(ack), LW'(3'b010));
    chk("single_idx", LW'(gidx), LW'(3'd1));
    req = '0;
    lines[1*LW +: LW] = rand_line();
    tick();
    chk("single_go",   LW'(go), LW'(1'b1));
    chk("single_line", fline, acl);
    valid = 1'b1;
    repeat (33) tick();
    chk("single_no_early_done", LW'(done), '0);
    tick();
    chk("single_done", LW'(done), LW'(3'b010));
    chk("single_go_low", LW'(go), '0);
    tick();
    chk("gap_busy", LW'(busy), LW'(1'b1));
    tick();
    chk("gap_busy_end", LW'(busy), '0);
    tick();
    valid = 1'b0;

    // Stalled feeder: watchdog, then pending requester 1 is served
    req = 3'b011;
    tick();
    chk("to_ack", LW'(ack), LW'(3'b001));
    req = 3'b010;
    tick();
    repeat (999) tick();
    chk("to_not_early", LW'(to), '0);
    tick();
    chk("to_pulse", LW'(to), LW'(1'b1));
    chk("to_no_done", LW'(done), '0);
    tick(); tick(); tick();
    chk("after_to_ack", LW'(ack), LW'(3'b010));
    req = '0; valid = 1'b1;
    tick();
    repeat (34) tick();
    chk("after_to_done", LW'(done), LW'(3'b010));
    valid = 1'b0;
    tick(); tick(); tick();

    // Reset in the middle of a line
    req = 3'b100;
    tick();
    req = '0;
    tick();
    valid = 1'b1;
    repeat (10) tick();
    valid = 1'b0; rst = 1'b1;
    tick();
    chk("midrst_go",   LW'(go),   '0);
    chk("midrst_busy", LW'(busy), '0);
    chk("midrst_line", fline, sp);
    rst = 1'b0; req = 3'b001;
    seen = 0;
    for (int w = 0; w < 5 && !seen; w++) begin
      tick();
      if (|ack) seen = 1;
    end
    chk("post_rst_ack", LW'(ack), LW'(3'b001));
    req = '0; valid = 1'b1; seen = 0;
    for (int w = 0; w < 60 && !seen; w++) begin
      tick();
      if (|done) seen = 1;
    end
    chk("post_rst_done", LW'(done), LW'(3'b001));
    valid = 1'b0;
    tick(); tick(); tick();

    // Randomized traffic, stray valids, drops, resets and stall windows
    for (int c = 0; c < 8000; c++) begin
      stall = ((c / 1500) % 4) == 3;
      rst   = ($urandom_range(0, 999) < 2);
      valid = !stall && ($urandom_range(0, 99) < 55);
      for (int k = 0; k < NR; k++) begin
        if (ack[CW'(k)]) begin
          if ($urandom_range(0, 99) < 60) req[CW'(k)] = 1'b0;
          if ($urandom_range(0, 99) < 50) lines[k*LW +: LW] = rand_line();
        end else if (!req[CW'(k)] && $urandom_range(0, 99) < 6) begin
          req[CW'(k)] = 1'b1;
          lines[k*LW +: LW] = rand_line();
        end else if (req[CW'(k)] && $urandom_range(0, 999) < 3) begin
          req[CW'(k)] = 1'b0;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
